act_mem_ext_port_ctrl: RTL

//  Initiator for the activation memory's external port (wr_en_ext/wr_addr_ext/wr_data_ext, rd_en_ext/rd_addr_ext/rd_data_ext).

---
 rtl/act_mem_ext_port_ctrl_pkg.sv | 16 +
 rtl/act_mem_rd_fifo.sv | 52 +++++
 rtl/act_mem_ext_port_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/act_mem_ext_port_ctrl_pkg.sv
// Shared defaults and FSM state type for the activation-memory external-port initiator.
package act_mem_ext_port_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF = 14;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned LEN_W_DEF  = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD,
        ST_RD_DRAIN,
        ST_FIN
    } state_e;

endpackage

// File: rtl/act_mem_rd_fifo.sv
// Two-entry read-data FIFO; a push and a pop may happen in the same cycle.
module act_mem_rd_fifo
    import act_mem_ext_port_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        cnt_q;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop_i && (cnt_q != 2'd0);
    assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= !wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= !rd_ptr_q;
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + 2'd1;
            end else if (do_pop && !do_push) begin
                cnt_q <= cnt_q - 2'd1;
            end
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/act_mem_ext_port_ctrl.sv
// Burst initiator for the activation memory external port: stream writes in, stream reads out.
module act_mem_ext_port_ctrl
    import act_mem_ext_port_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              wr_en_ext,
    output logic [ADDR_W-1:0] wr_addr_ext,
    output logic [DATA_W-1:0] wr_data_ext,
    output logic              rd_en_ext,
    output logic [ADDR_W-1:0] rd_addr_ext,
    input  logic [DATA_W-1:0] rd_data_ext
);

    // Extra headroom bit so a long len cannot wrap the end-address sum back into range.
    localparam int unsigned SUM_W = ((ADDR_W + 1 > LEN_W) ? ADDR_W + 1 : LEN_W) + 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [LEN_W-1:0]  pop_cnt_q, pop_cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              inflight_q;

    logic [SUM_W-1:0]  cmd_end;
    logic              cmd_illegal;
    logic [1:0]        fifo_cnt;
    logic              pop;
    logic              wr_fire;
    logic              rd_room;
    logic              rd_issue;
    logic              last_beat;
    logic              last_pop;

    assign cmd_end     = SUM_W'(cmd_base) + SUM_W'(cmd_len);
    assign cmd_illegal = (cmd_len == '0) || (cmd_end > (SUM_W'(1) << ADDR_W));

    assign m_valid   = (fifo_cnt != 2'd0);
    assign pop       = m_valid && m_ready;
    assign wr_fire   = (state_q == ST_WR) && s_valid;
    // Words already buffered or in flight, less the one leaving now, must leave a free slot.
    assign rd_room   = ({1'b0, fifo_cnt} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
    assign rd_issue  = (state_q == ST_RD) && rd_room;
    assign last_beat = (beat_cnt_q == len_q - LEN_W'(1));
    assign last_pop  = (pop_cnt_q == len_q - LEN_W'(1));

    always_comb begin
        state_d    = state_q;
        addr_cnt_d = addr_cnt_q;
        beat_cnt_d = beat_cnt_q;
        pop_cnt_d  = pop_cnt_q;
        len_d      = len_q;
        err_d      = err_q;
        rd_addr_d  = rd_addr_q;
        if (pop) begin
            pop_cnt_d = pop_cnt_q + LEN_W'(1);
        end
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    len_d      = cmd_len;
                    addr_cnt_d = cmd_base;
                    beat_cnt_d = '0;
                    pop_cnt_d  = '0;
                    err_d      = cmd_illegal;
                    if (cmd_illegal) begin
                        state_d = ST_FIN;
                    end else if (cmd_write) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_WR: begin
                if (wr_fire) begin
                    addr_cnt_d = addr_cnt_q + ADDR_W'(1);
                    beat_cnt_d = beat_cnt_q + LEN_W'(1);
                    if (last_beat) begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_RD: begin
                if (rd_issue) begin
                    rd_addr_d  = addr_cnt_q;
                    addr_cnt_d = addr_cnt_q + ADDR_W'(1);
                    beat_cnt_d = beat_cnt_q + LEN_W'(1);
                    if (last_beat) begin
                        state_d = ST_RD_DRAIN;
                    end
                end
            end
            ST_RD_DRAIN: begin
                if (pop && last_pop && !inflight_q) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_cnt_q <= '0;
            beat_cnt_q <= '0;
            pop_cnt_q  <= '0;
            len_q      <= '0;
            err_q      <= 1'b0;
            rd_addr_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_cnt_q <= addr_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            pop_cnt_q  <= pop_cnt_d;
            len_q      <= len_d;
            err_q      <= err_d;
            rd_addr_q  <= rd_addr_d;
            inflight_q <= rd_issue;
        end
    end

    act_mem_rd_fifo #(
        .DATA_W (DATA_W)
    ) u_rd_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (inflight_q),
        .push_data_i (rd_data_ext),
        .pop_i       (pop),
        .head_o      (m_data),
        .count_o     (fifo_cnt)
    );

    assign cmd_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_FIN);
    assign err         = done && err_q;
    assign s_ready     = (state_q == ST_WR);
    assign m_last      = m_valid && last_pop;
    assign wr_en_ext   = wr_fire;
    assign wr_addr_ext = wr_fire ? addr_cnt_q : '0;
    assign wr_data_ext = wr_fire ? s_data : '0;
    assign rd_en_ext   = rd_issue;
    // Held rather than zeroed when idle: the memory samples it every cycle to pick the read half.
    assign rd_addr_ext = rd_issue ? addr_cnt_q : rd_addr_q;

endmodule
